// File: rtl/core_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects,
// the load result-select code and the memory wait FSM states.
package core_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } mc_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count up, hold at all-ones, clear on request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush,
// variable-latency memory wait FSM with watchdog, and perf counters.
module hazard_unit_mc
  import core_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              PCSrcE,
  input  logic [1:0]        ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  input  logic              PerfClr,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              TimeoutErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic              WaitState
);

  mc_state_t       r_state;
  mc_state_t       w_state_nxt;
  logic            w_mem_stall;
  logic            w_lw_stall;
  logic            w_flush_inc;
  logic            w_wait_clr;
  logic            w_wait_inc;
  logic            w_to_hit;
  logic            r_timeout;
  logic [TO_W-1:0] w_wait_cnt;

  assign w_mem_stall = MemReqM & ~MemReadyM;
  assign w_lw_stall  = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));

  // Operand forwarding select; the younger M-stage result wins over W.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      ForwardAE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      ForwardAE = FWD_W;
    end
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      ForwardBE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      ForwardBE = FWD_W;
    end
  end

  // Stall/flush enables: memory wait freezes everything and holds the
  // branch in E, so the redirect is only taken once the access completes.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      FlushD = PCSrcE;
    end else begin
      FlushD = PCSrcE;
      FlushE = PCSrcE;
    end
  end

  // Flushes attributable to a taken branch (a load-use bubble alone is not counted).
  assign w_flush_inc = PCSrcE & ~w_mem_stall;

  // Wait FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait FSM next state: enter on a stalled access, leave once it is no longer stalled.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_mem_stall)  w_state_nxt = ST_WAIT;
      ST_WAIT: if (!w_mem_stall) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign WaitState  = (r_state == ST_WAIT);
  assign w_wait_clr = (r_state == ST_RUN);
  assign w_wait_inc = (r_state == ST_WAIT) & w_mem_stall;

  sat_counter #(.W(TO_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_wait_clr),
    .inc   (w_wait_inc),
    .q     (w_wait_cnt)
  );

  generate
    if (TIMEOUT != 0) begin : g_watchdog
      assign w_to_hit = (w_wait_cnt >= TO_W'(TIMEOUT));
    end else begin : g_no_watchdog
      assign w_to_hit = 1'b0;
    end
  endgenerate

  // Sticky watchdog flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_to_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign TimeoutErr = r_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (PerfClr),
    .inc   (StallF),
    .q     (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (PerfClr),
    .inc   (w_flush_inc),
    .q     (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: a default-parameter instance and a small
// instance (CNT_W=3, TIMEOUT=4, TO_W=3) share stimulus; a cycle model
// pushes expected outputs to a queue that is popped at sample time.
module tb_hazard_unit_mc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM, PerfClr;
  logic [1:0] ResultSrcE;

  logic        b_SF, b_SD, b_SE, b_SM, b_FD, b_FE, b_FW, b_TO, b_WS;
  logic [1:0]  b_FA, b_FB;
  logic [15:0] b_SC, b_FC;
  logic        s_SF, s_SD, s_SE, s_SM, s_FD, s_FE, s_FW, s_TO, s_WS;
  logic [1:0]  s_FA, s_FB;
  logic [2:0]  s_SC, s_FC;

  hazard_unit_mc u_big (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .PerfClr(PerfClr),
    .StallF(b_SF), .StallD(b_SD), .StallE(b_SE), .StallM(b_SM),
    .FlushD(b_FD), .FlushE(b_FE), .FlushW(b_FW),
    .ForwardAE(b_FA), .ForwardBE(b_FB), .TimeoutErr(b_TO),
    .StallCnt(b_SC), .FlushCnt(b_FC), .WaitState(b_WS)
  );

  hazard_unit_mc #(.CNT_W(3), .TIMEOUT(4), .TO_W(3)) u_small (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .PerfClr(PerfClr),
    .StallF(s_SF), .StallD(s_SD), .StallE(s_SE), .StallM(s_SM),
    .FlushD(s_FD), .FlushE(s_FE), .FlushW(s_FW),
    .ForwardAE(s_FA), .ForwardBE(s_FB), .TimeoutErr(s_TO),
    .StallCnt(s_SC), .FlushCnt(s_FC), .WaitState(s_WS)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       pc, rwm, rww, req, rdy, clr;
    logic [1:0] rsrc;
  } stim_t;

  typedef struct {
    logic [6:0] sf;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    logic [1:0] fa, fb;
    logic       ws, to_s, to_b;
    int         sc_s, fc_s, sc_b, fc_b;
  } exp_t;

  stim_t s;
  exp_t  q[$];

  // Reference model state
  logic m_wait;
  int   m_wc_s, m_wc_b, m_sc_s, m_fc_s, m_sc_b, m_fc_b;
  logic m_to_s, m_to_b;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; PCSrcE = s.pc; ResultSrcE = s.rsrc;
    RegWriteM = s.rwm; RegWriteW = s.rww; MemReqM = s.req; MemReadyM = s.rdy;
    PerfClr = s.clr;
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (s.rwm && s.rdm != 5'd0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 5'd0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_zero();
    m_wait = 1'b0; m_wc_s = 0; m_wc_b = 0; m_sc_s = 0; m_fc_s = 0;
    m_sc_b = 0; m_fc_b = 0; m_to_s = 1'b0; m_to_b = 1'b0;
  endtask

  // One clock: drive at negedge, predict, compare, then advance the model
  // to account for the following posedge.
  task automatic cycle();
    exp_t e, g;
    logic ms, lw;
    @(negedge clk);
    apply();
    #1;
    ms = s.req & ~s.rdy;
    lw = (s.rsrc == 2'b01) && (s.rde != 5'd0) && (s.rs1d == s.rde || s.rs2d == s.rde);
    if (ms)      e.sf = 7'b1111_001;
    else if (lw) e.sf = {4'b1100, s.pc, 1'b1, 1'b0};
    else         e.sf = {4'b0000, s.pc, s.pc, 1'b0};
    e.fa = fwd(s.rs1e); e.fb = fwd(s.rs2e);
    e.ws = m_wait; e.to_s = m_to_s; e.to_b = m_to_b;
    e.sc_s = m_sc_s; e.fc_s = m_fc_s; e.sc_b = m_sc_b; e.fc_b = m_fc_b;
    q.push_back(e);

    g = q.pop_front();
    check("s_stallflush", 32'({s_SF, s_SD, s_SE, s_SM, s_FD, s_FE, s_FW}), 32'(g.sf));
    check("b_stallflush", 32'({b_SF, b_SD, b_SE, b_SM, b_FD, b_FE, b_FW}), 32'(g.sf));
    check("s_fwdA", 32'(s_FA), 32'(g.fa));
    check("s_fwdB", 32'(s_FB), 32'(g.fb));
    check("b_fwdA", 32'(b_FA), 32'(g.fa));
    check("b_fwdB", 32'(b_FB), 32'(g.fb));
    check("s_waitstate", 32'(s_WS), 32'(g.ws));
    check("b_waitstate", 32'(b_WS), 32'(g.ws));
    check("s_timeout", 32'(s_TO), 32'(g.to_s));
    check("b_timeout", 32'(b_TO), 32'(g.to_b));
    check("s_stallcnt", 32'(s_SC), 32'(g.sc_s));
    check("s_flushcnt", 32'(s_FC), 32'(g.fc_s));
    check("b_stallcnt", 32'(b_SC), 32'(g.sc_b));
    check("b_flushcnt", 32'(b_FC), 32'(g.fc_b));

    if (s.clr) begin
      m_sc_s = 0; m_fc_s = 0; m_sc_b = 0; m_fc_b = 0;
    end else begin
      if (e.sf[6]) begin
        m_sc_s = sat_inc(m_sc_s, 7); m_sc_b = sat_inc(m_sc_b, 65535);
      end
      if (s.pc && !ms) begin
        m_fc_s = sat_inc(m_fc_s, 7); m_fc_b = sat_inc(m_fc_b, 65535);
      end
    end
    if (m_wc_s >= 4)  m_to_s = 1'b1;
    if (m_wc_b >= 64) m_to_b = 1'b1;
    if (!m_wait) begin
      m_wc_s = 0; m_wc_b = 0;
    end else if (ms) begin
      m_wc_s = sat_inc(m_wc_s, 7); m_wc_b = sat_inc(m_wc_b, 255);
    end
    m_wait = ms;
  endtask

  task automatic repeat_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset mid-cycle; inputs are idled so the release cycle is inert.
  task automatic async_reset();
    @(posedge clk);
    #2;
    s = '{default: '0};
    apply();
    reset = 1'b1;
    #1;
    model_zero();
    check("rst_s_waitstate", 32'(s_WS), 32'(m_wait));
    check("rst_b_waitstate", 32'(b_WS), 32'(m_wait));
    check("rst_s_timeout",   32'(s_TO), 32'(m_to_s));
    check("rst_s_stallcnt",  32'(s_SC), 32'(m_sc_s));
    check("rst_s_flushcnt",  32'(s_FC), 32'(m_fc_s));
    check("rst_b_stallcnt",  32'(b_SC), 32'(m_sc_b));
    check("rst_s_waitcnt",   32'(u_small.w_wait_cnt), 32'(m_wc_s));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    s = '{default: '0};
    apply();
    reset = 1'b1;
    model_zero();
    async_reset();

    // Forwarding: M beats W, RdM=0 falls back to W, Rs=0 never forwards
    s.rdm = 5'd5; s.rwm = 1'b1; s.rs1e = 5'd5; s.rdw = 5'd5; s.rww = 1'b1;
    cycle();
    check("fwdA_M", 32'(s_FA), 32'h2);
    s.rdm = 5'd0;
    cycle();
    check("fwdA_W", 32'(s_FA), 32'h1);
    s.rs1e = 5'd0;
    cycle();
    s.rs2e = 5'd5; s.rdm = 5'd5; s.rwm = 1'b0;
    cycle();
    s.rwm = 1'b1; s.rdw = 5'd9;
    cycle();

    // Load-use stall, with and without a taken branch, and RdE=0
    s = '{default: '0};
    s.rsrc = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    cycle();
    check("lw_stallF", 32'(s_SF), 32'h1);
    s = '{default: '0};
    cycle();
    check("lw_stallcnt", 32'(s_SC), 32'h1);
    s.rsrc = 2'b01; s.rde = 5'd3; s.rs1d = 5'd3; s.pc = 1'b1;
    cycle();
    s.rde = 5'd0; s.rs1d = 5'd0;
    cycle();

    // Memory wait: 3 stalled cycles then ready, branch held in E throughout
    async_reset();
    s.req = 1'b1; s.rdy = 1'b0; s.pc = 1'b1;
    repeat_cycles(3);
    s.rdy = 1'b1;
    cycle();
    s = '{default: '0};
    cycle();
    check("mem_stallcnt", 32'(s_SC), 32'h3);
    check("mem_flushcnt", 32'(s_FC), 32'h1);

    // Single-cycle access stays in RUN
    s.req = 1'b1; s.rdy = 1'b1;
    repeat_cycles(2);

    // Watchdog and counter saturation on the small instance
    async_reset();
    s.req = 1'b1; s.rdy = 1'b0;
    repeat_cycles(10);
    check("sat_stallcnt", 32'(s_SC), 32'h7);
    check("timeout_set", 32'(s_TO), 32'h1);
    s.clr = 1'b1;
    cycle();
    s.clr = 1'b0;
    cycle();
    check("clr_stallcnt", 32'(s_SC), 32'h0);
    check("clr_keeps_timeout", 32'(s_TO), 32'h1);
    s.rdy = 1'b1;
    cycle();
    s = '{default: '0};
    cycle();

    // Reset in the middle of a wait
    async_reset();
    s.req = 1'b1; s.rdy = 1'b0;
    repeat_cycles(3);
    @(posedge clk);
    #1;
    check("pre_rst_waitcnt", 32'(u_small.w_wait_cnt), 32'(m_wc_s));
    async_reset();
    repeat_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
